// File: rtl/audio_i2s_tx.sv
// ============================================================================
// audio_i2s_tx : lock-qualified I2S serializer with a one-pair sample buffer.
// Optional underrun counter port enabled by AUDIO_I2S_UNDERRUN_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module audio_i2s_tx #(
  parameter int DATA_WIDTH   = 24,
  parameter int BCLK_DIV     = 4,
  parameter int LOCK_HOLDOFF = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_locked,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_left,
  input  logic [DATA_WIDTH-1:0] s_right,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_dacdat,
  output logic                  running,
  output logic                  underrun
`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_count
`endif
);

  localparam int DIV_W  = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int HOLD_W = (LOCK_HOLDOFF > 2) ? $clog2(LOCK_HOLDOFF) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF  = DIV_W'(BCLK_DIV / 2);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LOCK_HOLDOFF - 1);
  localparam logic [4:0]        SLOT_LAST = 5'(DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLDOFF = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                state;
  logic                  sync_meta;
  logic                  lock_s;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic [5:0]            bit_cnt;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_left;
  logic [DATA_WIDTH-1:0] hold_right;
  logic [DATA_WIDTH-1:0] sh_left;
  logic [DATA_WIDTH-1:0] sh_right;

  logic             div_wrap;
  logic [DIV_W-1:0] div_next;
  logic [5:0]       bit_next;
  logic [4:0]       slot_next;
  logic             slot_data;
  logic             frame_load;
  logic             accept;
  logic             starve;

  assign div_wrap   = (div_cnt == DIV_LAST);
  assign div_next   = div_wrap ? '0 : div_cnt + DIV_W'(1);
  assign bit_next   = div_wrap ? bit_cnt + 6'd1 : bit_cnt;
  assign slot_next  = bit_next[4:0];
  // Slot position 0 is the I2S one-bit delay; data occupies 1..DATA_WIDTH.
  assign slot_data  = (slot_next != 5'd0) && (slot_next <= SLOT_LAST);
  assign frame_load = div_wrap && (bit_cnt == 6'd63);
  assign accept     = s_valid && s_ready;
  assign starve     = (state == ST_RUN) && lock_s && frame_load && !hold_full && !accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta  <= 1'b0;
      lock_s     <= 1'b0;
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      hold_full  <= 1'b0;
      hold_left  <= '0;
      hold_right <= '0;
      sh_left    <= '0;
      sh_right   <= '0;
      s_ready    <= 1'b0;
      i2s_bclk   <= 1'b0;
      i2s_lrclk  <= 1'b0;
      i2s_dacdat <= 1'b0;
      running    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      sync_meta <= pll_locked;
      lock_s    <= sync_meta;
      underrun  <= starve;
      if (!lock_s) begin
        // Lock loss truncates whatever frame is in flight.
        state      <= ST_IDLE;
        hold_cnt   <= '0;
        div_cnt    <= '0;
        bit_cnt    <= '0;
        hold_full  <= 1'b0;
        hold_left  <= '0;
        hold_right <= '0;
        sh_left    <= '0;
        sh_right   <= '0;
        s_ready    <= 1'b0;
        i2s_bclk   <= 1'b0;
        i2s_lrclk  <= 1'b0;
        i2s_dacdat <= 1'b0;
        running    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state    <= ST_HOLDOFF;
            hold_cnt <= '0;
          end
          ST_HOLDOFF: begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= ST_RUN;
              running  <= 1'b1;
              s_ready  <= 1'b1;
              div_cnt  <= '0;
              bit_cnt  <= '0;
              sh_left  <= '0;
              sh_right <= '0;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          ST_RUN: begin
            div_cnt   <= div_next;
            bit_cnt   <= bit_next;
            i2s_bclk  <= (div_next >= DIV_HALF);
            i2s_lrclk <= bit_next[5];
            if (div_wrap) begin
              i2s_dacdat <= slot_data &&
                            (bit_next[5] ? sh_right[DATA_WIDTH-1] : sh_left[DATA_WIDTH-1]);
              if (slot_data) begin
                if (bit_next[5]) sh_right <= sh_right << 1;
                else             sh_left  <= sh_left << 1;
              end
            end
            if (frame_load) begin
              // A pair offered on the load cycle itself goes straight to the frame.
              if (hold_full) begin
                sh_left  <= hold_left;
                sh_right <= hold_right;
              end else if (accept) begin
                sh_left  <= s_left;
                sh_right <= s_right;
              end else begin
                sh_left  <= '0;
                sh_right <= '0;
              end
              hold_full <= 1'b0;
              s_ready   <= 1'b1;
            end else if (accept) begin
              hold_left  <= s_left;
              hold_right <= s_right;
              hold_full  <= 1'b1;
              s_ready    <= 1'b0;
            end else begin
              s_ready <= !hold_full;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef AUDIO_I2S_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      underrun_count <= 16'd0;
    end else if (starve && (underrun_count != 16'hFFFF)) begin
      underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire
